// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
//
// Load handshake (valid/ready): a transfer happens on a rising CLK edge where
// LOAD=1 and READY=1. VALUE must be stable while LOAD is high. READY stays low
// from the edge after a transfer until the frame boundary that commits the
// shadow frame, and is high again on the cycle after that commit edge.
// A LOAD while READY=0 is dropped, not queued.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] VALUE,
    output logic                READY,
    output logic [3:0]          BCD,
    output logic [DIGITS-1:0]   AN,
    output logic                FRAME,
    output logic [1:0]          dbg_state
);

    localparam int IW   = $clog2(DIGITS);
    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                frame_q, frame_d;
    logic                commit;
    logic [DIGITS-1:0]   sup;
`ifdef SEG_SCAN_LZB_EN
    logic                lead_zero;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        an_d      = '1;
        bcd_d     = bcd_q;
        frame_d   = 1'b0;
        commit    = 1'b0;
        sup       = '0;

        if (LOAD && !pending_q) begin
            shadow_d  = VALUE;
            pending_d = 1'b1;
        end

        if (!EN) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    cnt_d   = CW'(DIV - 1);
                    commit  = 1'b1;
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_BLANK;
                        cnt_d   = CW'(BLANK - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = CW'(DIV - 1);
                        if (idx_q == IW'(DIGITS - 1)) begin
                            idx_d  = '0;
                            commit = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A commit can never collide with an accepted load: loads need pending low.
        if (commit && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        frame_d = commit;

`ifdef SEG_SCAN_LZB_EN
        // Walk down from the top digit; digit 0 always stays visible.
        lead_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead_zero = lead_zero && (active_d[4*k +: 4] == 4'd0);
            sup[k]    = lead_zero && (k != 0);
        end
`endif

        if (state_d == ST_DRIVE) begin
            bcd_d = active_d[{idx_d, 2'b00} +: 4];
            if ((bcd_d <= 4'd9) && !sup[idx_d]) begin
                an_d = ~(DIGITS'(1) << idx_d);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            bcd_q     <= 4'd0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            frame_q   <= frame_d;
        end
    end

    assign READY     = ~pending_q;
    assign BCD       = bcd_q;
    assign AN        = an_q;
    assign FRAME     = frame_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, DIV=4, BLANK=2); expected frames follow
// SEG_SCAN_LZB_EN when that macro is defined for the build.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int BLANK  = 2;
    localparam int SLOT   = DIV + BLANK;
    localparam logic [1:0] ST_IDLE = 2'd0;

    // Frame expectation layout: slot k at [8k+:8] = {an_k, bcd_k}.
    localparam logic [31:0] EXP_ZERO  = 32'h70B0_D0E0;
    localparam logic [31:0] EXP_1234  = 32'h71B2_D3E4;
    localparam logic [31:0] EXP_9A07  = 32'h79FA_D0E7;
`ifdef SEG_SCAN_LZB_EN
    localparam logic [31:0] EXP_0042  = 32'hF0F0_D4E2;
    localparam logic [31:0] EXP_ZLZB  = 32'hF0F0_F0E0;
`else
    localparam logic [31:0] EXP_0042  = 32'h70B0_D4E2;
    localparam logic [31:0] EXP_ZLZB  = 32'h70B0_D0E0;
`endif

    logic                CLK;
    logic                RST;
    logic                EN;
    logic                LOAD;
    logic [4*DIGITS-1:0] VALUE;
    logic                READY;
    logic [3:0]          BCD;
    logic [DIGITS-1:0]   AN;
    logic                FRAME;
    logic [1:0]          dbg_state;

    logic [31:0] exp_q[$];
    int checks;
    int failures;

    seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .LOAD     (LOAD),
        .VALUE    (VALUE),
        .READY    (READY),
        .BCD      (BCD),
        .AN       (AN),
        .FRAME    (FRAME),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FRAME && n < 100);
        check("frame_seen", {31'd0, FRAME}, 32'd1);
    endtask

    // monitor: on each FRAME with an expectation queued, check the whole frame
    initial begin : monitor
        logic [31:0] exp_frame;
        logic [3:0]  e_an;
        logic [3:0]  e_bcd;
        logic        e_frame;
        logic        slot_ok;
        logic [3:0]  bad_an;
        logic [3:0]  bad_bcd;
        logic        bad_frame;
        int          bad_c;
        forever begin
            @(negedge CLK);
            if (RST && FRAME && exp_q.size() > 0) begin
                exp_frame = exp_q.pop_front();
                for (int k = 0; k < DIGITS; k++) begin
                    slot_ok   = 1'b1;
                    bad_an    = 4'h0;
                    bad_bcd   = 4'h0;
                    bad_frame = 1'b0;
                    bad_c     = 0;
                    for (int c = 0; c < SLOT; c++) begin
                        if (k != 0 || c != 0) @(negedge CLK);
                        e_an    = (c < DIV) ? exp_frame[8*k+4 +: 4] : 4'hF;
                        e_bcd   = exp_frame[8*k +: 4];
                        e_frame = (k == 0 && c == 0);
                        if (slot_ok && (AN !== e_an || BCD !== e_bcd || FRAME !== e_frame)) begin
                            slot_ok   = 1'b0;
                            bad_an    = AN;
                            bad_bcd   = BCD;
                            bad_frame = FRAME;
                            bad_c     = c;
                        end
                    end
                    checks++;
                    if (!slot_ok) begin
                        failures++;
                        $display("FAIL frame_slot%0d cycle %0d: got AN=%b BCD=%h FRAME=%b expected AN=%b BCD=%h",
                                 k, bad_c, bad_an, bad_bcd, bad_frame,
                                 (bad_c < DIV) ? exp_frame[8*k+4 +: 4] : 4'hF, exp_frame[8*k +: 4]);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin : stimulus
        int n;
        checks   = 0;
        failures = 0;
        RST   = 1'b0;
        EN    = 1'b1;
        LOAD  = 1'b0;
        VALUE = '0;

        // reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_an", {28'd0, AN}, 32'hF);
        check("rst_bcd", {28'd0, BCD}, 32'h0);
        check("rst_ready", {31'd0, READY}, 32'd1);
        check("rst_frame", {31'd0, FRAME}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // first two frames: all zeros, FRAME every 24 clocks
        exp_q.push_back(EXP_ZERO);
        exp_q.push_back(EXP_ZERO);
        RST = 1'b1;
        wait_frame(n);
        check("first_frame_latency", n, 32'd1);
        wait_frame(n);
        check("frame_period", n, 32'(DIGITS * SLOT));

        // load 1234 mid-frame; the frame in progress still shows zeros
        @(posedge CLK);
        exp_q.push_back(EXP_ZERO);
        exp_q.push_back(EXP_1234);
        step(24);
        check("f3_start", {31'd0, FRAME}, 32'd1);
        step(6);
        LOAD  = 1'b1;
        VALUE = 16'h1234;
        step(1);
        check("ready_drop", {31'd0, READY}, 32'd0);
        VALUE = 16'h5678;
        step(4);
        LOAD = 1'b0;
        check("ignored_load_ready", {31'd0, READY}, 32'd0);
        step(12);
        check("ready_before_commit", {31'd0, READY}, 32'd0);
        // LOAD presented on the commit edge is taken one cycle later
        LOAD  = 1'b1;
        VALUE = 16'h9A07;
        step(1);
        check("ready_after_commit", {31'd0, READY}, 32'd1);
        check("f4_start", {31'd0, FRAME}, 32'd1);
        step(1);
        check("late_accept", {31'd0, READY}, 32'd0);
        LOAD = 1'b0;
        exp_q.push_back(EXP_9A07);

        // frame 5 shows 9A07; queue 5678 for frame 6
        step(23);
        check("f5_start", {31'd0, FRAME}, 32'd1);
        step(2);
        LOAD  = 1'b1;
        VALUE = 16'h5678;
        step(1);
        LOAD = 1'b0;
        check("ready_drop_5678", {31'd0, READY}, 32'd0);
        step(21);
        check("f6_start", {31'd0, FRAME}, 32'd1);

        // EN drop during digit 2 drive
        step(13);
        check("pre_drop_an", {28'd0, AN}, 32'hB);
        check("pre_drop_bcd", {28'd0, BCD}, 32'h6);
        EN = 1'b0;
        step(1);
        check("en_drop_an", {28'd0, AN}, 32'hF);
        check("en_drop_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        step(3);
        check("parked_an", {28'd0, AN}, 32'hF);
        check("parked_frame", {31'd0, FRAME}, 32'd0);

        // handshake while parked; pending frame commits on restart
        LOAD  = 1'b1;
        VALUE = 16'h0042;
        step(1);
        LOAD = 1'b0;
        check("idle_load", {31'd0, READY}, 32'd0);
        exp_q.push_back(EXP_0042);
        step(2);
        EN = 1'b1;
        step(1);
        check("restart_frame", {31'd0, FRAME}, 32'd1);
        check("restart_ready", {31'd0, READY}, 32'd1);

        // all-zero value for the following frame
        step(2);
        LOAD  = 1'b1;
        VALUE = 16'h0000;
        step(1);
        LOAD = 1'b0;
        exp_q.push_back(EXP_ZLZB);
        step(21);
        check("r1_start", {31'd0, FRAME}, 32'd1);
        step(24);
        check("r2_start", {31'd0, FRAME}, 32'd1);
        step(1);
        check("pre_rst_an", {28'd0, AN}, 32'hE);

        // asynchronous reset mid-slot, sampled before the next clock edge
        #1;
        RST = 1'b0;
        #1;
        check("async_rst_an", {28'd0, AN}, 32'hF);
        check("async_rst_ready", {31'd0, READY}, 32'd1);
        check("async_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Holds a frame of BCD digits and steps through them at a programmable rate.
- Presents one BCD nibble at a time to the downstream BCD-to-7-segment decoder and drives the matching active-low digit enable.
- Digit updates arrive via a valid/ready load handshake and are applied only at frame boundaries, so the display never tears.

Parameters:
- DIGITS, 4: number of display digits; legal range 2..8.
- DIV, 50000: clocks each digit is driven per scan slot; must be >= 1.
- BLANK, 16: dead-time clocks between slots with all digits off (anti-ghosting); must be >= 1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  scan enable; low blanks the display and parks the scanner.
- LOAD  input  1  load request; VALUE is valid while high.
- VALUE  input  4*DIGITS  new BCD frame; nibble k = digit k, digit 0 least significant.
- READY  output  1  high when a LOAD can be accepted.
- BCD  output  4  BCD nibble to the decoder.
- AN  output  DIGITS  digit enables, active-low, one-hot-low or all-high.
- FRAME  output  1  one-cycle pulse when digit 0 starts a new frame.

Behaviour:
- Reset (RST=0, async):
  - State IDLE; AN all 1; BCD=0; READY=1; FRAME=0.
  - Active and shadow registers cleared to 0; pending=0; digit index=0; counter=0.
- Load handshake:
  - A transfer occurs on a rising edge with LOAD=1 and READY=1: VALUE is copied to shadow, pending is set, and READY goes 0 the next cycle.
  - READY returns to 1 the cycle after the shadow is committed.
  - LOAD while READY=0 is ignored; it is not queued.
- States:
  - IDLE:
    - AN all 1.
    - EN=1 moves to DRIVE with index=0 and counter=DIV-1.
    - Commits pending shadow to active on entry to DRIVE and pulses FRAME.
  - DRIVE:
    - BCD = active[index].
    - AN[index]=0, others 1, unless the digit is suppressed (see below).
    - Counter decrements each clock; at 0 go to BLANK with counter=BLANK-1.
  - BLANK:
    - AN all 1; BCD holds its value.
    - Counter decrements; at 0 advance the index and go to DRIVE with counter=DIV-1.
  - Wrap:
    - When the index advances from DIGITS-1 to 0, commit pending shadow to active (clear pending) in the same edge.
    - Assert FRAME for that first DRIVE cycle of digit 0.
- Timing:
  - Each slot lasts DIV+BLANK clocks; a frame lasts DIGITS*(DIV+BLANK) clocks.
  - AN changes are registered: the first DRIVE cycle shows the new AN.
- EN=0 in any state:
  - Next edge goes to IDLE, AN all 1, index=0.
  - Pending is preserved.
  - The handshake keeps working.
- Invalid digit (nibble > 9): BCD passes through, but AN for that slot stays all 1, since the decoder output is undefined for such codes.
- Simultaneous commit and LOAD: READY is still 0 on that edge, so LOAD is not accepted; it is accepted one cycle later.
- DIV=1 and BLANK=1 must work: 2-clock slots.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- When defined:
  - Digits above the most significant nonzero digit are suppressed: AN stays all 1 for those slots.
  - Digit 0 is never suppressed, so the value 0 shows a single "0".
  - The suppression mask is computed from the active register only.
- When undefined:
  - All valid digits are displayed, including leading zeros.
- Slot timing is identical in both cases.

Test Plan:
1. Reset and first frame (DIGITS=4, DIV=4, BLANK=2, EN=1 after reset):
   - AN=1111 during reset.
   - FRAME pulses once on the first DRIVE cycle.
   - AN sequence per 6-clock slot is 1110×4, 1111×2, then 1101, 1011, 0111.
   - BCD=0 throughout.
   - FRAME repeats every 24 clocks.
2. Load mid-frame:
   - Stimulus: LOAD with VALUE=16'h1234 during digit 1.
   - READY drops the next cycle.
   - Current frame still shows 0s.
   - At the next FRAME, BCD sequence is 4, 3, 2, 1.
   - READY returns high the cycle after the commit.
3. Back-to-back load: a second LOAD=16'h5678 while READY=0 is ignored; the display shows 1234, not 5678.
4. Invalid digit:
   - Stimulus: VALUE=16'h9A07.
   - Digit 2 slot has AN=1111 and BCD=A.
   - Digits 0, 1 and 3 are driven normally.
5. EN drop mid-slot:
   - Stimulus: deassert EN during the digit 2 DRIVE.
   - Next cycle AN=1111, state IDLE.
   - On reassert, scanning restarts at digit 0 with a FRAME pulse.
   - Assert RST low mid-slot: AN=1111 immediately, without waiting for a clock edge.
6. SEG_SCAN_LZB_EN defined:
   - VALUE=16'h0042: digits 3 and 2 show AN=1111, digits 1 and 0 are driven.
   - VALUE=16'h0000: only digit 0 is driven.
